arch_retire_commit: RTL
=======================

Name: arch_retire_commit

Overview:
- Sits directly downstream of the ROB retire port and consumes up to ROB_MAX_RETIRE retired instructions per cycle.
- Writes their results into the 32-entry architectural register file.
- Detects a retiring mispredicted branch: squashes younger lanes, issues a PC redirect, then streams the full architectural state to the F-RAT/PRF over a multi-cycle recovery sequence.

Parameters:
- ROB_MAX_RETIRE, 4, retire lanes per cycle (lane 0 oldest).
- DATA_LEN, 32, data/PC width.
- SRC_LEN, 5, architectural register index width.
- NUM_AREGS, 32, architectural registers (x0 hardwired zero).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- val_ret  in  ROB_MAX_RETIRE  lane valid from ROB.
- rd_ret  in  ROB_MAX_RETIRE x SRC_LEN  destination register per lane.
- data_ret  in  ROB_MAX_RETIRE x DATA_LEN  result per lane.
- pc_ret  in  ROB_MAX_RETIRE x DATA_LEN  branch target per lane (meaningful when branch_ret set).
- branch_ret  in  ROB_MAX_RETIRE  lane is a mispredicted branch needing redirect.
- arch_rd_addr  in  2 x SRC_LEN  debug/recovery read addresses.
- arch_rd_data  out  2 x DATA_LEN  combinational read of committed state (no bypass).
- ret_stall  out  1  ROB must hold retire outputs.
- redirect_val  out  1  one-cycle redirect pulse.
- redirect_pc  out  DATA_LEN  redirect target.
- flush  out  1  pipeline flush, high for the whole recovery.
- rec_val  out  1  recovery stream entry valid.
- rec_idx  out  SRC_LEN  recovery register index.
- rec_data  out  DATA_LEN  recovery register value.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all arch registers 0; FSM IDLE; ret_stall, redirect_val, flush, rec_val = 0; redirect_pc, rec_idx, rec_data = 0.
- Squash: lane i is squashed if any lane j<i has val_ret[j] && branch_ret[j].
- Commit qualification: lane i commits when val_ret[i] && !squashed[i] && rd_ret[i]!=0 && state==IDLE.
- The mispredicted branch lane itself commits, so link-register writes land.
- Commit latency: commit writes the RF at the next posedge and is visible on arch_rd_data in the following cycle.
- Same rd on multiple committing lanes: the highest-numbered (youngest) lane wins.
- x0: never written; arch_rd_data for address 0 always reads 0.
- FSM states: IDLE, REDIRECT, RECOVER.
- IDLE → REDIRECT when any unsquashed lane has val_ret && branch_ret.
  - Same edge: commit qualified lanes; register redirect_pc = pc_ret of the lowest such lane.
  - Next cycle: redirect_val=1, flush=1, ret_stall=1.
- REDIRECT → RECOVER after exactly 1 cycle; rec_idx starts at 0.
- RECOVER:
  - rec_val=1 each cycle; rec_idx increments 0..31.
  - rec_data = arch register[rec_idx], x0 reads 0.
  - flush=1 and ret_stall=1 throughout.
  - After rec_idx=31 is presented: → IDLE; flush, ret_stall, rec_val drop the next cycle.
- Total recovery length: 1 + 32 = 33 cycles with flush high.
- Outside IDLE: all val_ret is ignored (no commit, no new redirect). The ROB holds its outputs under ret_stall.
- redirect_val is a single-cycle pulse, never reasserted within one recovery.
- Reset mid-REDIRECT/RECOVER: next cycle is IDLE with all outputs at reset values; the RF is cleared.
- rec_idx wraps naturally at SRC_LEN but is never driven past 31.

Optional Feature:
- Macro: RETIRE_PERF_CNT_EN.
- Defined:
  - Adds output instret_cnt (64 bits) and output mispred_cnt (32 bits), both reset to 0.
  - instret_cnt += number of committing or squash-surviving valid lanes per IDLE cycle, counting rd=0 lanes.
  - mispred_cnt += 1 per IDLE → REDIRECT transition.
  - Both counters wrap modulo width.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single-lane commit: val_ret=0001, rd_ret[0]=5, data_ret[0]=0xDEADBEEF → arch_rd_addr=5 reads 0xDEADBEEF two edges after input; ret_stall stays 0.
- 4-lane rd collision: all lanes rd=7, data 1/2/3/4 → x7=4. Lane writing rd=0 with 0x55 → x0 still reads 0.
- Mid-bundle mispredict: val_ret=1111, branch_ret=0010, pc_ret[1]=0x100, lanes 0–3 rd=1..4 data 0xA..0xD → x1=0xA, x2=0xB, x3/x4 unchanged. Next cycle redirect_val=1 with redirect_pc=0x100 for exactly 1 cycle; flush high 33 cycles.
- Recovery stream: preload x1..x31=index*3, then trigger mispredict → rec_val for 32 consecutive cycles with rec_idx 0..31, rec_data 0,3,6,…,93. Retire inputs presented during recovery are not committed.
- Reset mid-RECOVER: assert rst at rec_idx=10 → next cycle flush=0, rec_val=0, all regs read 0. A subsequent commit behaves normally.
- With RETIRE_PERF_CNT_EN: retire 3 lanes/cycle for 10 cycles, then 1 mispredict bundle of 4 with branch at lane 0 → instret_cnt=31, mispred_cnt=1.

Source files
------------

// File: rtl/arch_retire_commit.sv
// arch_retire_commit: commits retired ROB lanes into the 32-entry architectural
// register file, detects a retiring mispredicted branch, squashes younger lanes,
// pulses a PC redirect and then streams the full architectural state out for
// F-RAT/PRF recovery.
// Optional build macro: RETIRE_PERF_CNT_EN adds instret_cnt / mispred_cnt.
module arch_retire_commit #(
    parameter int unsigned ROB_MAX_RETIRE = 4,
    parameter int unsigned DATA_LEN       = 32,
    parameter int unsigned SRC_LEN        = 5,
    parameter int unsigned NUM_AREGS      = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ROB_MAX_RETIRE-1:0]          val_ret,
    input  logic [ROB_MAX_RETIRE*SRC_LEN-1:0]  rd_ret,
    input  logic [ROB_MAX_RETIRE*DATA_LEN-1:0] data_ret,
    input  logic [ROB_MAX_RETIRE*DATA_LEN-1:0] pc_ret,
    input  logic [ROB_MAX_RETIRE-1:0]          branch_ret,
    input  logic [2*SRC_LEN-1:0]               arch_rd_addr,
    output logic [2*DATA_LEN-1:0]              arch_rd_data,
    output logic                               ret_stall,
    output logic                               redirect_val,
    output logic [DATA_LEN-1:0]                redirect_pc,
    output logic                               flush,
    output logic                               rec_val,
    output logic [SRC_LEN-1:0]                 rec_idx,
`ifdef RETIRE_PERF_CNT_EN
    output logic [DATA_LEN-1:0]                rec_data,
    output logic [63:0]                        instret_cnt,
    output logic [31:0]                        mispred_cnt
`else
    output logic [DATA_LEN-1:0]                rec_data
`endif
);

    typedef enum logic [1:0] {StIdle, StRedirect, StRecover} state_e;

    localparam logic [SRC_LEN-1:0] LastIdx = SRC_LEN'(NUM_AREGS - 1);

    state_e                    state_q;
    logic [DATA_LEN-1:0]       rf_q [NUM_AREGS];

    logic [ROB_MAX_RETIRE-1:0] surv;       // valid and not behind an older mispredict
    logic [ROB_MAX_RETIRE-1:0] commit_en;
    logic                      mispred;
    logic [DATA_LEN-1:0]       mispred_pc;
    logic [SRC_LEN-1:0]        rec_idx_nxt;
    logic [DATA_LEN-1:0]       rec_data_nxt;

    // Squash younger lanes behind the oldest valid mispredict and qualify commits.
    always_comb begin
        logic seen;
        seen       = 1'b0;
        surv       = '0;
        commit_en  = '0;
        mispred    = 1'b0;
        mispred_pc = '0;
        for (int i = 0; i < int'(ROB_MAX_RETIRE); i++) begin
            surv[i]      = val_ret[i] && !seen;
            commit_en[i] = surv[i] && (rd_ret[i*SRC_LEN +: SRC_LEN] != '0)
                           && (state_q == StIdle);
            // Only the first surviving branch can match: everything after it is squashed.
            if (surv[i] && branch_ret[i]) begin
                mispred    = (state_q == StIdle);
                mispred_pc = pc_ret[i*DATA_LEN +: DATA_LEN];
            end
            seen = seen | (val_ret[i] & branch_ret[i]);
        end
    end

    // Committed-state read ports; no bypass of same-cycle commits, x0 reads zero.
    always_comb begin
        arch_rd_data = '0;
        for (int p = 0; p < 2; p++) begin
            if (arch_rd_addr[p*SRC_LEN +: SRC_LEN] != '0) begin
                arch_rd_data[p*DATA_LEN +: DATA_LEN] = rf_q[arch_rd_addr[p*SRC_LEN +: SRC_LEN]];
            end
        end
    end

    // Next entry of the recovery stream.
    always_comb begin
        rec_idx_nxt  = rec_idx + SRC_LEN'(1);
        rec_data_nxt = (rec_idx_nxt == '0) ? '0 : rf_q[rec_idx_nxt];
    end

    // Register file: later (younger) lanes override earlier ones on the same rd.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NUM_AREGS); k++) begin
                rf_q[k] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(ROB_MAX_RETIRE); i++) begin
                if (commit_en[i]) begin
                    rf_q[rd_ret[i*SRC_LEN +: SRC_LEN]] <= data_ret[i*DATA_LEN +: DATA_LEN];
                end
            end
        end
    end

    // Redirect / recovery FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ret_stall    <= 1'b0;
            redirect_val <= 1'b0;
            redirect_pc  <= '0;
            flush        <= 1'b0;
            rec_val      <= 1'b0;
            rec_idx      <= '0;
            rec_data     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mispred) begin
                        state_q      <= StRedirect;
                        redirect_val <= 1'b1;
                        redirect_pc  <= mispred_pc;
                        flush        <= 1'b1;
                        ret_stall    <= 1'b1;
                    end
                end
                StRedirect: begin
                    state_q      <= StRecover;
                    redirect_val <= 1'b0;
                    rec_val      <= 1'b1;
                    rec_idx      <= '0;
                    rec_data     <= '0;
                end
                StRecover: begin
                    if (rec_idx == LastIdx) begin
                        state_q   <= StIdle;
                        rec_val   <= 1'b0;
                        rec_idx   <= '0;
                        rec_data  <= '0;
                        flush     <= 1'b0;
                        ret_stall <= 1'b0;
                    end else begin
                        rec_idx  <= rec_idx_nxt;
                        rec_data <= rec_data_nxt;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef RETIRE_PERF_CNT_EN
    localparam int unsigned CntW = $clog2(ROB_MAX_RETIRE + 1);

    logic [CntW-1:0] surv_cnt;

    // Surviving valid lanes this cycle, rd=0 lanes included.
    always_comb begin
        surv_cnt = '0;
        for (int i = 0; i < int'(ROB_MAX_RETIRE); i++) begin
            surv_cnt = surv_cnt + CntW'(surv[i]);
        end
    end

    // Retired-instruction and mispredict counters, wrapping at their width.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_cnt <= '0;
            mispred_cnt <= '0;
        end else begin
            if (state_q == StIdle) begin
                instret_cnt <= instret_cnt + 64'(surv_cnt);
            end
            if (mispred) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
